delta_trig_gen: RTL and testbench
=================================

# delta_trig_gen

Initiator side of the delta reset handshake. Issues a fixed-width `delta_trig` pulse on a software request or, optionally, on a LIVE rising edge. It then tracks the receiver's `delta_rst` assertion and release before it will issue another pulse. It sits in the layer-2 control logic upstream of the delta reset receiver and reports completion, timeouts and the trigger count to the register block.

## Interface
- `TRIG_WIDTH`, 4: cycles `delta_trig` is held high (1..15).
- `ACK_TIMEOUT`, 255: maximum cycles to wait in each of the ack and release phases.
- `HOLDOFF`, 16: idle cycles enforced after each handshake before the next pulse.
- `CNT_W`, 16: width of `trig_count`.

Ports:
- `clk` input 1: single clock for the block. All logic is on `posedge clk`.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 1: single-cycle trigger request.
- `live` input 1: LIVE level, synchronous to `clk`. Used only with `DELTA_TRIG_LIVE_EN`.
- `delta_rst` input 1: reset indication returned by the receiver.
- `err_clr` input 1: clears `timeout_err`.
- `delta_trig` output 1: registered trigger pulse to the receiver.
- `busy` output 1: high in every state except IDLE.
- `timeout_err` output 1: sticky error flag.
- `trig_count` output CNT_W: number of pulses issued. Wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, PULSE, WAIT_ACK, WAIT_REL, HOLDOFF. Reset state is IDLE.
- Reset values: all outputs 0, `pending` = 0, `live_d` = 0, all timers 0.
- Trigger event: `req`, OR'd with `live & ~live_d` when the macro is enabled.
- IDLE with an event, or with `pending` = 1:
  - go to PULSE;
  - clear `pending`;
  - increment `trig_count`.
- PULSE:
  - `delta_trig` = 1 for exactly TRIG_WIDTH cycles.
  - `ack_seen` is set if `delta_rst` is sampled high in any PULSE cycle.
  - On exit, go to WAIT_REL if `ack_seen` is set, otherwise to WAIT_ACK.
- WAIT_ACK:
  - `delta_rst` sampled high → WAIT_REL.
  - Timer reaches ACK_TIMEOUT → set `timeout_err`, go to HOLDOFF.
- WAIT_REL:
  - `delta_rst` sampled low → HOLDOFF.
  - Timer reaches ACK_TIMEOUT → set `timeout_err`, go to HOLDOFF.
- HOLDOFF: HOLDOFF cycles, then IDLE.
- Events arriving while `busy`:
  - The first event sets `pending`.
  - Further events are dropped.
  - An event in the same cycle as the IDLE→PULSE transition counts as arriving while busy.
- `timeout_err`:
  - Cleared by `err_clr`.
  - A set and `err_clr` in the same cycle: the set wins.
- Reset mid-operation: asynchronous return to IDLE. `delta_trig` drops to 0 immediately and `pending` is lost.

## Timing
- Event sampled at edge N: state is PULSE and `delta_trig` = 1 from N+1 through N+TRIG_WIDTH. The `trig_count` update is visible at N+1.
- With a matching receiver, `delta_rst` rises one cycle after `delta_trig` rises and stays high about 101 cycles. Acknowledgement therefore normally occurs inside PULSE.
- WAIT_ACK and WAIT_REL timers restart at 0 on entry to each state. Timeout fires on the cycle the timer equals ACK_TIMEOUT.
- Minimum spacing between `delta_trig` rising edges: TRIG_WIDTH + 1 + HOLDOFF + 1 cycles, with the ack arriving in PULSE and an immediate release.
- `busy` is registered and asserts one cycle after the event is sampled, together with `delta_trig`.
- `live_d` resets to 0. If `live` is already high at reset release, no edge is generated.

## Configuration
- `DELTA_TRIG_LIVE_EN` defined: a LIVE rising edge is a trigger source in addition to `req`.
- `DELTA_TRIG_LIVE_EN` undefined:
  - `live` is unused and `live_d` is not instantiated;
  - only `req` triggers.

## Structure
- Shared package `delta_pkg` holds:
  - the FSM state enum (3-bit encoding);
  - the default TRIG_WIDTH, ACK_TIMEOUT and HOLDOFF constants, shared with the receiver side.
- One sub-module: `delta_timer`, a loadable down/up counter with a terminal flag. It is reused for the PULSE width, ack/release timeout and HOLDOFF counts. The FSM and registers stay in the top module.

## Test plan
- Single `req` at cycle 10, receiver model asserts `delta_rst` at 12 for 101 cycles:
  - `delta_trig` high cycles 11–14;
  - `trig_count` = 1;
  - `busy` falls after WAIT_REL exit plus 16 HOLDOFF cycles;
  - `timeout_err` = 0.
- No receiver response (`delta_rst` held 0):
  - WAIT_ACK times out after 255 cycles;
  - `timeout_err` = 1;
  - the block returns to IDLE after HOLDOFF.
- `err_clr` then clears the flag.
- Three `req` pulses while busy: exactly one extra pulse is issued after HOLDOFF, `trig_count` = 2, and the third request is dropped.
- `delta_rst` stuck high:
  - WAIT_REL timeout at 255;
  - `timeout_err` = 1;
  - the next `req` is still served.
- `rst` asserted during PULSE cycle 2:
  - `delta_trig` is 0 immediately;
  - all outputs are 0;
  - a later `req` gives `trig_count` = 1.
- With `DELTA_TRIG_LIVE_EN`: `live` rises at cycle 20 → `delta_trig` at 21. Without the macro, `live` toggles → no pulse.

Source files
------------

// File: rtl/delta_pkg.sv
// Shared definitions for the delta reset handshake (initiator and receiver).
// Holds the initiator FSM state encoding and the default timing constants.
package delta_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PULSE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_HOLDOFF  = 3'd4
    } delta_state_t;

    localparam int unsigned DEF_TRIG_WIDTH  = 4;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;
    localparam int unsigned DEF_HOLDOFF     = 16;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/delta_timer.sv
// Loadable up/down counter with a zero (terminal) flag. Shared by the pulse
// width, ack/release timeout and holdoff phases of the trigger generator.
module delta_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority over counting; count direction selected by up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/delta_trig_gen.sv
// Initiator side of the delta reset handshake: issues a TRIG_WIDTH-cycle
// delta_trig pulse per request, then tracks delta_rst assert/release with
// timeouts and a holdoff before the next pulse.
// Optional macro DELTA_TRIG_LIVE_EN: a rising edge on live also triggers.
module delta_trig_gen
    import delta_pkg::*;
#(
    parameter int unsigned TRIG_WIDTH  = DEF_TRIG_WIDTH,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned HOLDOFF     = DEF_HOLDOFF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             live,
    input  logic             delta_rst,
    input  logic             err_clr,
    output logic             delta_trig,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] trig_count
);

    localparam int unsigned TMAX = max3(TRIG_WIDTH, ACK_TIMEOUT, HOLDOFF);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] PULSE_LOAD = TW'(TRIG_WIDTH - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLDOFF - 1);
    localparam logic [TW-1:0] ACK_LIMIT  = TW'(ACK_TIMEOUT);

    delta_state_t  state;
    logic          pending;
    logic          ack_seen;
    logic          trig_ev;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_en;
    logic          tmr_up;
    logic [TW-1:0] tmr_count;
    logic          tmr_zero;
    logic          tmr_at_limit;

`ifdef DELTA_TRIG_LIVE_EN
    logic live_d;
    logic live_arm;

    // live_arm suppresses a false edge when live is already high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_d   <= 1'b0;
            live_arm <= 1'b0;
        end else begin
            live_d   <= live;
            live_arm <= 1'b1;
        end
    end

    assign trig_ev = req | (live & ~live_d & live_arm);
`else
    logic unused_live;
    assign unused_live = live;
    assign trig_ev     = req;
`endif

    assign tmr_at_limit = (tmr_count == ACK_LIMIT);

    // Timer control: PULSE and HOLDOFF count down to zero, WAIT phases count up from zero.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        tmr_up   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_ev || pending) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) tmr_load = 1'b1;
                else          tmr_en   = 1'b1;
            end
            ST_WAIT_ACK: begin
                if (delta_rst) begin
                    tmr_load = 1'b1;
                end else if (tmr_at_limit) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else begin
                    tmr_en = 1'b1;
                    tmr_up = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!delta_rst || tmr_at_limit) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else begin
                    tmr_en = 1'b1;
                    tmr_up = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (!tmr_zero) tmr_en = 1'b1;
            end
            default: ;
        endcase
    end

    delta_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .up       (tmr_up),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Handshake FSM with registered outputs, pending-request latch and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            delta_trig  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            trig_count  <= '0;
            pending     <= 1'b0;
            ack_seen    <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (err_clr) timeout_err <= 1'b0;
            if (state != ST_IDLE && trig_ev) pending <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (trig_ev || pending) begin
                        state      <= ST_PULSE;
                        delta_trig <= 1'b1;
                        busy       <= 1'b1;
                        trig_count <= trig_count + 1'b1;
                        ack_seen   <= 1'b0;
                        // An event coinciding with a pending-driven start is kept.
                        pending    <= pending & trig_ev;
                    end
                end
                ST_PULSE: begin
                    ack_seen <= ack_seen | delta_rst;
                    if (tmr_zero) begin
                        delta_trig <= 1'b0;
                        state      <= (ack_seen || delta_rst) ? ST_WAIT_REL : ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (delta_rst) begin
                        state <= ST_WAIT_REL;
                    end else if (tmr_at_limit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_HOLDOFF;
                    end
                end
                ST_WAIT_REL: begin
                    if (!delta_rst) begin
                        state <= ST_HOLDOFF;
                    end else if (tmr_at_limit) begin
                        timeout_err <= 1'b1;
                        state       <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (tmr_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    delta_trig <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_trig_gen.sv
// Self-checking bench for delta_trig_gen: table of single-handshake scenarios,
// hand-written corner sequences, and a randomized run against an interval model.
module tb_delta_trig_gen;

    localparam int TW = 4;
    localparam int AT = 255;
    localparam int HO = 16;
    localparam int CW = 16;
    localparam int N  = 4000;
    localparam int L  = N + 800;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          live;
    logic          delta_rst;
    logic          err_clr;
    logic          delta_trig;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] trig_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dly;       // cycles after the request edge when delta_rst is first sampled high
        int len;       // cycles delta_rst stays high (0: never)
        int clr_off;   // offset of a one-cycle err_clr (-1: none)
        int exp_trig;  // cycles delta_trig is high
        int exp_busy;  // cycles busy is high
        int exp_err;   // timeout_err once idle
    } row_t;

    row_t rows[7];

    bit s_req[L], s_d[L], s_clr[L], s_live[L];
    bit m_trig[L], m_busy[L], m_err[L], m_inc[L], m_set[L];
    int m_cnt[L];

    delta_trig_gen #(
        .TRIG_WIDTH  (TW),
        .ACK_TIMEOUT (AT),
        .HOLDOFF     (HO),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .live        (live),
        .delta_rst   (delta_rst),
        .err_clr     (err_clr),
        .delta_trig  (delta_trig),
        .busy        (busy),
        .timeout_err (timeout_err),
        .trig_count  (trig_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keeps a responsive receiver (delta_rst follows delta_trig by one cycle) until idle.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            req = 1'b0; err_clr = 1'b0; delta_rst = delta_trig;
            tick();
            n++;
        end
        @(negedge clk);
        delta_rst = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    function automatic bit ev_at(input int k);
        bit e;
        e = s_req[k];
`ifdef DELTA_TRIG_LIVE_EN
        if (k > 0 && s_live[k] && !s_live[k-1]) e = 1'b1;
`endif
        return e;
    endfunction

    // Interval model: for each pulse, scan the delta_rst waveform to find where
    // each phase ends, then paint the expected output arrays.
    task automatic build_model();
        int k, s, e1, r, h, idle_at;
        bit pend, by_pend, ack, tmo;
        for (int i = 0; i < L; i++) begin
            m_trig[i] = 0; m_busy[i] = 0; m_err[i] = 0;
            m_inc[i] = 0; m_set[i] = 0; m_cnt[i] = 0;
        end
        k = 0;
        pend = 0;
        while (k < N) begin
            if (!pend && !ev_at(k)) begin
                k++;
                continue;
            end
            s = k;
            by_pend = pend;
            e1 = s + TW;
            ack = 0;
            for (int j = s + 1; j <= e1; j++) if (s_d[j]) ack = 1;
            tmo = 0;
            r = -1;
            h = -1;
            if (ack) begin
                r = e1;
            end else begin
                for (int j = 0; j <= AT; j++) begin
                    if (s_d[e1 + 1 + j]) begin
                        r = e1 + 1 + j;
                        break;
                    end
                end
                if (r < 0) begin
                    tmo = 1;
                    h = e1 + 1 + AT;
                end
            end
            if (r >= 0) begin
                for (int j = 0; j <= AT; j++) begin
                    if (!s_d[r + 1 + j]) begin
                        h = r + 1 + j;
                        break;
                    end
                end
                if (h < 0) begin
                    tmo = 1;
                    h = r + 1 + AT;
                end
            end
            idle_at = h + HO;
            m_inc[s] = 1;
            m_set[h] = tmo;
            for (int i = s; i < s + TW; i++) m_trig[i] = 1;
            for (int i = s; i < idle_at; i++) m_busy[i] = 1;
            pend = by_pend && ev_at(s);
            for (int i = s + 1; i <= idle_at; i++) if (ev_at(i)) pend = 1;
            k = idle_at + 1;
        end
        for (int i = 0; i < L; i++) begin
            if (i == 0) begin
                m_cnt[i] = int'(m_inc[i]);
                m_err[i] = m_set[i];
            end else begin
                m_cnt[i] = (m_cnt[i-1] + int'(m_inc[i])) % 65536;
                m_err[i] = m_set[i] | (!s_clr[i] & m_err[i-1]);
            end
        end
    endtask

    initial begin
        int base, ntrig, nbusy, rises, off2, seen;
        bit prev, lvl, llv;
        int run, lrun;

        rows[0] = '{1, 101,   -1, 4, 118, 0};  // matching receiver
        rows[1] = '{1,   1,   -1, 4,  21, 0};  // ack in PULSE, immediate release
        rows[2] = '{0,   0,  260, 4, 276, 1};  // no ack; clear on timeout edge loses
        rows[3] = '{10, 20,   -1, 4,  46, 0};  // ack in WAIT_ACK
        rows[4] = '{1, 1000, 261, 4, 276, 0};  // stuck high, cleared after timeout
        rows[5] = '{4,   3,   -1, 4,  23, 0};  // ack on last PULSE cycle
        rows[6] = '{5,   5,   -1, 4,  26, 0};  // ack on first WAIT_ACK cycle

        rst = 1'b1; req = 1'b0; live = 1'b0; delta_rst = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({delta_trig, busy, timeout_err, trig_count}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single handshakes.
        for (int i = 0; i < 7; i++) begin
            base = int'(trig_count);
            ntrig = 0;
            nbusy = 0;
            @(negedge clk);
            req = 1'b1; delta_rst = 1'b0; err_clr = (rows[i].clr_off == 0);
            tick();
            ntrig += int'(delta_trig);
            nbusy += int'(busy);
            for (int c = 1; c < 450; c++) begin
                @(negedge clk);
                req = 1'b0;
                delta_rst = (rows[i].len > 0 && c >= rows[i].dly && c < rows[i].dly + rows[i].len);
                err_clr = (c == rows[i].clr_off);
                tick();
                ntrig += int'(delta_trig);
                nbusy += int'(busy);
                if (!busy) break;
            end
            @(negedge clk);
            delta_rst = 1'b0; err_clr = 1'b0;
            check($sformatf("row%0d_trig_cycles", i), ntrig, rows[i].exp_trig);
            check($sformatf("row%0d_busy_cycles", i), nbusy, rows[i].exp_busy);
            check($sformatf("row%0d_timeout_err", i), int'(timeout_err), rows[i].exp_err);
            check($sformatf("row%0d_count", i), int'(trig_count), (base + 1) % 65536);
            wait_idle($sformatf("row%0d_idle", i));
            err_clr = 1'b1;
            tick();
            @(negedge clk);
            err_clr = 1'b0;
            check($sformatf("row%0d_err_clr", i), int'(timeout_err), 0);
        end

        // Three requests while busy: one extra pulse, third dropped.
        base = int'(trig_count);
        rises = 0;
        off2 = -1;
        prev = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            req = (c == 0 || c == 3 || c == 6);
            delta_rst = delta_trig;
            tick();
            if (delta_trig && !prev) begin
                rises++;
                if (rises == 2) off2 = c;
            end
            prev = delta_trig;
        end
        check("queued_pulse_count", rises, 2);
        check("queued_pulse_spacing", off2, 22);
        check("queued_trig_count", int'(trig_count), (base + 2) % 65536);
        wait_idle("queued_idle");

        // Reset during the second PULSE cycle.
        @(negedge clk);
        req = 1'b1;
        tick();
        @(negedge clk);
        req = 1'b0;
        tick();
        check("pulse_before_reset", int'(delta_trig), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({delta_trig, busy, timeout_err, trig_count}), 0);
        @(negedge clk);
        rst = 1'b0; req = 1'b1;
        tick();
        check("after_reset_req", int'({delta_trig, trig_count}), int'({1'b1, 16'd1}));
        wait_idle("after_reset_idle");

`ifdef DELTA_TRIG_LIVE_EN
        base = int'(trig_count);
        repeat (3) begin @(negedge clk); req = 1'b0; live = 1'b0; tick(); end
        @(negedge clk);
        live = 1'b1;
        tick();
        check("live_edge_pulse", int'({delta_trig, trig_count}), int'({1'b1, 16'(base + 1)}));
        wait_idle("live_idle");
        @(negedge clk);
        rst = 1'b1; live = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin tick(); seen |= int'(busy); end
        check("live_high_at_reset", int'({seen[0], trig_count}), 0);
        live = 1'b0;
`else
        base = int'(trig_count);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            req = 1'b0;
            live = c[0];
            tick();
            seen |= int'(busy);
        end
        check("live_ignored", int'({seen[0], trig_count}), int'({1'b0, 16'(base)}));
        live = 1'b0;
`endif

        // Randomized run against the interval model.
        lvl = 1'b1; run = 0; llv = 1'b1; lrun = 0;
        for (int k = 0; k < L; k++) begin
            s_req[k] = 0; s_d[k] = 0; s_clr[k] = 0; s_live[k] = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (run == 0) begin lvl = !lvl; run = $urandom_range(1, 300); end
            if (lrun == 0) begin llv = !llv; lrun = $urandom_range(1, 40); end
            s_d[k] = lvl; run--;
            s_live[k] = llv; lrun--;
            s_req[k] = ($urandom_range(0, 24) == 0);
            s_clr[k] = ($urandom_range(0, 59) == 0);
        end
        build_model();

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            rst = 1'b0;
            req = s_req[k]; delta_rst = s_d[k]; err_clr = s_clr[k]; live = s_live[k];
            tick();
            check($sformatf("rand_cycle%0d {trig,busy,err,count}", k),
                  int'({delta_trig, busy, timeout_err, trig_count}),
                  int'({m_trig[k], m_busy[k], m_err[k], 16'(m_cnt[k])}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
